// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Load/store pipeline stage placed directly after execute. Non-memory
//   instructions pass through with one cycle of latency. Loads and stores are
//   captured into hold registers and run over a req/gnt/rvalid data-memory
//   port, with the upstream pipeline stalled until the access completes.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   instr_i           instruction from execute
//   alu_result_i      ALU result / effective address
//   rs2_i             store data source
//   instr_o           instruction to write-back (0 = bubble)
//   result_o          write-back data
//   sel_rd_o          destination register (0 = no write)
//   stall_o           upstream must hold its inputs while high
//   misalign_o        one-cycle pulse when a misaligned access is dropped
//   dmem_req_o        memory request
//   dmem_we_o         1 = store
//   dmem_addr_o       word-aligned memory address
//   dmem_be_o         byte enables
//   dmem_wdata_o      lane-replicated store data
//   dmem_gnt_i        request accepted
//   dmem_rvalid_i     load data valid
//   dmem_rdata_i      load data
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       rs2_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       result_o,
  output logic [4:0]        sel_rd_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, next_state;

  logic [31:0] hold_instr;
  logic [31:0] hold_addr;
  logic [31:0] hold_rs2;

  logic [31:0] instr_d;
  logic [31:0] result_d;
  logic [4:0]  sel_rd_d;
  logic        misalign_d;

  logic        in_load, in_store, in_mem, in_rtype, in_misalign;
  logic        capture;
  logic        hold_store;
  logic [2:0]  hold_f3;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Decode of the incoming instruction. Unsupported funct3 values on the
  // LOAD/STORE opcodes fall through as ordinary non-memory instructions.
  always_comb begin
    in_load     = 1'b0;
    in_store    = 1'b0;
    in_misalign = 1'b0;
    if (instr_i[6:0] == OPC_LOAD) begin
      case (instr_i[14:12])
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_load = 1'b1;
        default:                                 in_load = 1'b0;
      endcase
    end
    if (instr_i[6:0] == OPC_STORE) begin
      case (instr_i[14:12])
        3'b000, 3'b001, 3'b010: in_store = 1'b1;
        default:                in_store = 1'b0;
      endcase
    end
    // funct3[1:0] encodes the access size for both loads and stores
    case (instr_i[13:12])
      2'b01:   in_misalign = alu_result_i[0];
      2'b10:   in_misalign = (alu_result_i[1:0] != 2'b00);
      default: in_misalign = 1'b0;
    endcase
  end

  assign in_mem     = in_load | in_store;
  assign in_rtype   = (instr_i[6:0] == OPC_OP);
  assign capture    = (state == IDLE) && in_mem && !in_misalign;
  assign hold_store = (hold_instr[6:0] == OPC_STORE);
  assign hold_f3    = hold_instr[14:12];

  // Load data extraction from the returned word, using the held address
  // to pick the byte/halfword lane.
  always_comb begin
    case (hold_addr[1:0])
      2'b00:   load_byte = dmem_rdata_i[7:0];
      2'b01:   load_byte = dmem_rdata_i[15:8];
      2'b10:   load_byte = dmem_rdata_i[23:16];
      default: load_byte = dmem_rdata_i[31:24];
    endcase
    load_half = hold_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (hold_f3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. gnt and rvalid only matter in the state expecting them,
  // so a stray rvalid after a reset-abandoned load is harmlessly ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = REQ;
      REQ:     if (dmem_gnt_i) next_state = hold_store ? IDLE : WAIT_R;
      WAIT_R:  if (dmem_rvalid_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: memory port driven from the hold registers so it stays
  // stable until gnt, plus the next values of the write-back registers.
  always_comb begin
    stall_o      = (state != IDLE);
    dmem_req_o   = (state == REQ);
    dmem_we_o    = (state == REQ) && hold_store;
    dmem_addr_o  = {hold_addr[ADDR_W-1:2], 2'b00};
    case (hold_f3[1:0])
      2'b00:   dmem_be_o = 4'b0001 << hold_addr[1:0];
      2'b01:   dmem_be_o = 4'b0011 << hold_addr[1:0];
      default: dmem_be_o = 4'b1111;
    endcase
    case (hold_f3[1:0])
      2'b00:   dmem_wdata_o = {4{hold_rs2[7:0]}};
      2'b01:   dmem_wdata_o = {2{hold_rs2[15:0]}};
      default: dmem_wdata_o = hold_rs2;
    endcase

    instr_d    = 32'h0;
    result_d   = 32'h0;
    sel_rd_d   = 5'd0;
    misalign_d = 1'b0;
    case (state)
      IDLE: begin
        if (in_mem) begin
          misalign_d = in_misalign;
        end else begin
          instr_d  = instr_i;
          result_d = alu_result_i;
          sel_rd_d = in_rtype ? instr_i[11:7] : 5'd0;
        end
      end
      REQ: begin
        if (dmem_gnt_i && hold_store) instr_d = hold_instr;
      end
      WAIT_R: begin
        if (dmem_rvalid_i) begin
          instr_d  = hold_instr;
          result_d = load_data;
          sel_rd_d = hold_instr[11:7];
        end
      end
      default: ;
    endcase
  end

  // Write-back registers and hold registers for the in-flight access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_o    <= 32'h0;
      result_o   <= 32'h0;
      sel_rd_o   <= 5'd0;
      misalign_o <= 1'b0;
      hold_instr <= 32'h0;
      hold_addr  <= 32'h0;
      hold_rs2   <= 32'h0;
    end else begin
      instr_o    <= instr_d;
      result_o   <= result_d;
      sel_rd_o   <= sel_rd_d;
      misalign_o <= misalign_d;
      if (capture) begin
        hold_instr <= instr_i;
        hold_addr  <= alu_result_i;
        hold_rs2   <= rs2_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//   Directed and randomized stimulus for mem_access. Expected values come from
//   a behavioural model that works in terms of access size, byte offset and
//   lane arithmetic rather than the DUT's case tables.
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, alu_result_i, rs2_i;
  logic [31:0] instr_o, result_o;
  logic [4:0]  sel_rd_o;
  logic        stall_o, misalign_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] ADD_X1 = 32'h003100B3;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_i(instr_i), .alu_result_i(alu_result_i), .rs2_i(rs2_i),
    .instr_o(instr_o), .result_o(result_o), .sel_rd_o(sel_rd_o),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch with tag and values
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural model. kind: 0 non-memory, 1 misaligned, 2 store, 3 load.
  task automatic modelInstr(input logic [31:0] ins, input logic [31:0] alu,
                            input logic [31:0] rs2, input logic [31:0] rdata,
                            output int kind, output logic [31:0] expAddr,
                            output logic [3:0] expBe, output logic [31:0] expWdata,
                            output logic [31:0] expResult, output logic [4:0] expSel);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        isLoad, isStore;
    int          size, off;
    logic [31:0] mask, val;
    op = ins[6:0];
    f3 = ins[14:12];
    isLoad  = (op == 7'h03) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    isStore = (op == 7'h23) && (f3 <= 3'd2);
    size    = 1 << f3[1:0];
    off     = int'(alu[1:0]);
    expAddr = alu - 32'(off);
    expBe   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) expWdata[8*i +: 8] = rs2[8*(i % size) +: 8];
    expResult = 32'h0;
    expSel    = 5'd0;
    if (!isLoad && !isStore) begin
      kind      = 0;
      expResult = alu;
      expSel    = (op == 7'h33) ? ins[11:7] : 5'd0;
    end else if ((alu % 32'(size)) != 0) begin
      kind = 1;
    end else if (isStore) begin
      kind = 2;
    end else begin
      kind = 3;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      val  = (rdata >> (8*off)) & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      expResult = val;
      expSel    = ins[11:7];
    end
  endtask

  // Presents one instruction, plays the memory side with the given gnt/rvalid
  // delays, and while stalled presents a follower instruction that must come
  // out exactly once, right after the memory access completes.
  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input int gntDly, input int rvDly,
                               input logic [31:0] follow, input logic [31:0] followAlu);
    int          kind, fKind;
    logic [31:0] eAddr, eWdata, eRes, fAddr, fWdata, fRes;
    logic [3:0]  eBe, fBe;
    logic [4:0]  eSel, fSel;
    modelInstr(ins, alu, rs2, rdata, kind, eAddr, eBe, eWdata, eRes, eSel);
    @(negedge clk);
    instr_i       = ins;
    alu_result_i  = alu;
    rs2_i         = rs2;
    dmem_gnt_i    = 1'($urandom);
    dmem_rvalid_i = 1'($urandom);
    dmem_rdata_i  = $urandom;
    @(posedge clk); #1;
    if (kind == 0) begin
      checkOutput({tag, ".instr"}, instr_o, ins);
      checkOutput({tag, ".result"}, result_o, eRes);
      checkOutput({tag, ".sel_rd"}, 32'(sel_rd_o), 32'(eSel));
      checkOutput({tag, ".stall"}, 32'(stall_o), 32'd0);
      checkOutput({tag, ".req"}, 32'(dmem_req_o), 32'd0);
      checkOutput({tag, ".misalign"}, 32'(misalign_o), 32'd0);
      return;
    end
    if (kind == 1) begin
      checkOutput({tag, ".misalign"}, 32'(misalign_o), 32'd1);
      checkOutput({tag, ".instr"}, instr_o, 32'h0);
      checkOutput({tag, ".sel_rd"}, 32'(sel_rd_o), 32'd0);
      checkOutput({tag, ".stall"}, 32'(stall_o), 32'd0);
      checkOutput({tag, ".req"}, 32'(dmem_req_o), 32'd0);
      return;
    end
    // request phase
    for (int k = 0; k <= gntDly; k++) begin
      @(negedge clk);
      if (k == 0) begin
        instr_i      = follow;
        alu_result_i = followAlu;
        rs2_i        = $urandom;
      end
      dmem_gnt_i    = (k == gntDly);
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = $urandom;
      checkOutput({tag, ".req_hi"}, 32'(dmem_req_o), 32'd1);
      checkOutput({tag, ".stall_hi"}, 32'(stall_o), 32'd1);
      checkOutput({tag, ".bubble"}, instr_o, 32'h0);
      checkOutput({tag, ".bubble_rd"}, 32'(sel_rd_o), 32'd0);
      checkOutput({tag, ".we"}, 32'(dmem_we_o), (kind == 2) ? 32'd1 : 32'd0);
      checkOutput({tag, ".addr"}, dmem_addr_o, eAddr);
      if (kind == 2) begin
        checkOutput({tag, ".be"}, 32'(dmem_be_o), 32'(eBe));
        checkOutput({tag, ".wdata"}, dmem_wdata_o, eWdata);
      end
      @(posedge clk);
    end
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    if (kind == 3) begin
      for (int k = 0; k <= rvDly; k++) begin
        if (k > 0) @(negedge clk);
        checkOutput({tag, ".wait_req"}, 32'(dmem_req_o), 32'd0);
        checkOutput({tag, ".wait_stall"}, 32'(stall_o), 32'd1);
        checkOutput({tag, ".wait_bubble"}, instr_o, 32'h0);
        dmem_rvalid_i = (k == rvDly);
        dmem_rdata_i  = (k == rvDly) ? rdata : $urandom;
        @(posedge clk);
      end
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
    checkOutput({tag, ".done_instr"}, instr_o, ins);
    checkOutput({tag, ".done_result"}, result_o, eRes);
    checkOutput({tag, ".done_rd"}, 32'(sel_rd_o), 32'(eSel));
    checkOutput({tag, ".done_stall"}, 32'(stall_o), 32'd0);
    modelInstr(follow, followAlu, 32'h0, 32'h0, fKind, fAddr, fBe, fWdata, fRes, fSel);
    @(posedge clk); #1;
    checkOutput({tag, ".follow_instr"}, instr_o, follow);
    checkOutput({tag, ".follow_result"}, result_o, fRes);
    checkOutput({tag, ".follow_rd"}, 32'(sel_rd_o), 32'(fSel));
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = op;
    r[14:12] = f3;
    r[11:7]  = rd;
    return r;
  endfunction

  initial begin
    logic [31:0] ins, alu, fol;
    int          t;
    logic [2:0]  f3;
    rst_n = 1'b0;
    instr_i = 32'h0; alu_result_i = 32'h0; rs2_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.instr", instr_o, 32'h0);
    checkOutput("reset.result", result_o, 32'h0);
    checkOutput("reset.sel_rd", 32'(sel_rd_o), 32'd0);
    checkOutput("reset.stall", 32'(stall_o), 32'd0);
    checkOutput("reset.req", 32'(dmem_req_o), 32'd0);
    checkOutput("reset.we", 32'(dmem_we_o), 32'd0);
    checkOutput("reset.misalign", 32'(misalign_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed steps");
    applyStimulus("add", ADD_X1, 32'h15, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    applyStimulus("sb", {7'd0, 5'd5, 5'd2, 3'b000, 5'd0, 7'b0100011}, 32'h103,
                  32'hAABBCCDD, 32'h0, 2, 0, ADD_X1, 32'h21);
    applyStimulus("lb", {12'd0, 5'd2, 3'b000, 5'd7, 7'b0000011}, 32'h202,
                  32'h0, 32'h12803456, 0, 3, ADD_X1, 32'h22);
    applyStimulus("lbu", {12'd0, 5'd2, 3'b100, 5'd7, 7'b0000011}, 32'h202,
                  32'h0, 32'h12803456, 0, 3, ADD_X1, 32'h23);
    applyStimulus("lh_mis", {12'd0, 5'd2, 3'b001, 5'd8, 7'b0000011}, 32'h201,
                  32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    applyStimulus("after_mis", ADD_X1, 32'h24, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // reset while a load waits for rvalid; the late rvalid must be ignored
    @(negedge clk);
    instr_i = {12'd0, 5'd2, 3'b010, 5'd9, 7'b0000011};
    alu_result_i = 32'h300;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_i = 32'h0; alu_result_i = 32'h0;
    dmem_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    checkOutput("rstwait.stall_before", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstwait.instr", instr_o, 32'h0);
    checkOutput("rstwait.stall", 32'(stall_o), 32'd0);
    checkOutput("rstwait.req", 32'(dmem_req_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    checkOutput("late_rvalid.instr", instr_o, 32'h0);
    checkOutput("late_rvalid.rd", 32'(sel_rd_o), 32'd0);
    checkOutput("late_rvalid.stall", 32'(stall_o), 32'd0);
    applyStimulus("lw_after_rst", {12'd0, 5'd2, 3'b010, 5'd9, 7'b0000011}, 32'h304,
                  32'h0, 32'hCAFEF00D, 1, 2, ADD_X1, 32'h25);

    $display("[TB] randomized steps");
    for (int n = 0; n < 200; n++) begin
      t   = int'($urandom_range(0, 5));
      f3  = 3'($urandom);
      alu = $urandom;
      if ($urandom_range(0, 2) != 0) alu[1:0] = 2'b00;
      case (t)
        0:       ins = mkInstr(7'h33, f3, 5'($urandom));
        1:       ins = mkInstr(7'h13, f3, 5'($urandom));
        2:       ins = mkInstr(($urandom_range(0, 1) != 0) ? 7'h03 : 7'h23,
                               3'(6 + $urandom_range(0, 1)), 5'($urandom));
        3, 4:    ins = mkInstr(7'h03, 3'(($urandom_range(0, 4) == 3) ? 4 :
                               ($urandom_range(0, 4) == 4) ? 5 : $urandom_range(0, 2)),
                               5'($urandom));
        default: ins = mkInstr(7'h23, 3'($urandom_range(0, 2)), 5'($urandom));
      endcase
      fol = mkInstr(7'h33, 3'($urandom), 5'($urandom));
      applyStimulus("rand", ins, alu, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fol, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
